r2r_dac_wavegen: RTL and testbench



---
 rtl/r2r_dac_wavegen.sv | 122 ++++++++++++
 tb/tb_r2r_dac_wavegen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/r2r_dac_wavegen.sv
// Waveform generator for an R2R ladder DAC: external pass-through, sawtooth,
// triangle and square, with a programmable tick divider, step and period sync.
module r2r_dac_wavegen #(
    parameter int unsigned DAC_WIDTH = 8,
    parameter int unsigned DIV_SHIFT = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [1:0]           mode,
    input  logic [DAC_WIDTH-1:0] data,
    input  logic                 load_divider,
    input  logic                 load_step,
    output logic [DAC_WIDTH-1:0] r2r_out,
    output logic                 sync
);

    localparam int unsigned CNT_W = DAC_WIDTH + DIV_SHIFT;
    localparam int unsigned SUM_W = DAC_WIDTH + 1;
    localparam logic [DAC_WIDTH-1:0] CODE_MAX = '1;

    typedef enum logic [1:0] {
        MODE_EXT = 2'b00,
        MODE_SAW = 2'b01,
        MODE_TRI = 2'b10,
        MODE_SQR = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [DAC_WIDTH-1:0] out_q, out_d;
    logic [DAC_WIDTH-1:0] div_q, div_d;
    logic [DAC_WIDTH-1:0] step_q, step_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    dir_e                 dir_q, dir_d;
    logic                 sync_q, sync_d;

    logic [CNT_W-1:0]     limit;
    logic                 tick;
    logic [SUM_W-1:0]     sum;

    assign limit   = CNT_W'(div_q) << DIV_SHIFT;
    assign tick    = (cnt_q >= limit);
    assign sum     = SUM_W'(out_q) + SUM_W'(step_q);
    assign r2r_out = out_q;
    assign sync    = sync_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_q  <= '0;
            div_q  <= '0;
            step_q <= DAC_WIDTH'(1);
            cnt_q  <= '0;
            dir_q  <= DIR_UP;
            sync_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            div_q  <= div_d;
            step_q <= step_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            sync_q <= sync_d;
        end
    end

    // Loads and waveform update; loaded values are seen by the compare from the next edge.
    always_comb begin
        div_d  = load_divider ? data : div_q;
        step_d = load_step ? data : step_q;
        out_d  = out_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        sync_d = 1'b0;

        if (mode_e'(mode) == MODE_EXT) begin
            out_d = data;
            cnt_d = '0;
            dir_d = DIR_UP;
        end else begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
            if (tick) begin
                case (mode_e'(mode))
                    MODE_SAW: begin
                        out_d  = sum[DAC_WIDTH-1:0];
                        sync_d = sum[DAC_WIDTH];
                    end
                    MODE_TRI: begin
                        if (dir_q == DIR_UP) begin
                            if (sum >= SUM_W'(CODE_MAX)) begin
                                out_d = CODE_MAX;
                                dir_d = DIR_DOWN;
                            end else begin
                                out_d = sum[DAC_WIDTH-1:0];
                            end
                        end else begin
                            if (out_q <= step_q) begin
                                out_d  = '0;
                                dir_d  = DIR_UP;
                                sync_d = 1'b1;
                            end else begin
                                out_d = out_q - step_q;
                            end
                        end
                    end
                    MODE_SQR: begin
                        out_d  = (out_q == '0) ? CODE_MAX : '0;
                        sync_d = (out_q == '0);
                    end
                    default: begin
                        out_d = out_q;
                    end
                endcase
            end
            if (mode_e'(mode) != MODE_TRI) begin
                dir_d = DIR_UP;
            end
        end
    end

endmodule

// File: tb/tb_r2r_dac_wavegen.sv
// Self-checking bench for r2r_dac_wavegen: directed scenarios plus randomized traffic
// against an arithmetic reference model of the waveform rules.
module tb_r2r_dac_wavegen;

    localparam int DW    = 8;
    localparam int SHIFT = 8;
    localparam int MAXC  = 255;

    logic          clk = 1'b0;
    logic          n_rst = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic [DW-1:0] data = '0;
    logic          load_divider = 1'b0;
    logic          load_step = 1'b0;
    logic [DW-1:0] r2r_out;
    logic          sync;

    int checks = 0;
    int failures = 0;
    bit run = 0;

    r2r_dac_wavegen #(.DAC_WIDTH(DW), .DIV_SHIFT(SHIFT)) dut (
        .clk(clk), .n_rst(n_rst), .mode(mode), .data(data),
        .load_divider(load_divider), .load_step(load_step),
        .r2r_out(r2r_out), .sync(sync)
    );

    always #5 clk = ~clk;

    // Reference model: integer arithmetic straight from the waveform rules.
    int m_out = 0, m_div = 0, m_step = 1, m_cnt = 0;
    bit m_down = 0, m_sync = 0;
    int n_div, n_step, m_sum;
    bit m_tick;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_out = 0; m_div = 0; m_step = 1; m_cnt = 0; m_down = 0; m_sync = 0;
        end else begin
            n_div  = load_divider ? int'(data) : m_div;
            n_step = load_step ? int'(data) : m_step;
            m_sync = 0;
            if (mode == 2'd0) begin
                m_out = int'(data); m_cnt = 0; m_down = 0;
            end else begin
                m_tick = (m_cnt >= m_div * (1 << SHIFT));
                m_cnt  = m_tick ? 0 : m_cnt + 1;
                if (m_tick) begin
                    m_sum = m_out + m_step;
                    if (mode == 2'd1) begin
                        m_out  = m_sum % (MAXC + 1);
                        m_sync = (m_sum > MAXC);
                    end else if (mode == 2'd2) begin
                        if (!m_down) begin
                            if (m_sum >= MAXC) begin m_out = MAXC; m_down = 1; end
                            else m_out = m_sum;
                        end else begin
                            if (m_out <= m_step) begin m_out = 0; m_down = 0; m_sync = 1; end
                            else m_out = m_out - m_step;
                        end
                    end else begin
                        m_sync = (m_out == 0);
                        m_out  = (m_out == 0) ? MAXC : 0;
                    end
                end
                if (mode != 2'd2) m_down = 0;
            end
            m_div = n_div; m_step = n_step;
        end
    end

    always @(negedge clk) begin
        if (run && n_rst) begin
            checks++;
            if (int'(r2r_out) != m_out || sync !== m_sync) begin
                failures++;
                $display("FAIL model t=%0t actual out=%0d sync=%0b required out=%0d sync=%0b",
                         $time, r2r_out, sync, m_out, m_sync);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Cycles until r2r_out changes, bounded.
    task automatic gap_to_change(output int n);
        int prev;
        prev = int'(r2r_out);
        n = 0;
        do begin cyc(); n++; end while (int'(r2r_out) == prev && n < 3000);
    endtask

    // In external mode, load step then park output at 0 before switching.
    task automatic prep(input int stp, input int dv, input logic [1:0] md);
        mode = 2'd0; data = DW'(dv); load_divider = 1'b1; cyc();
        load_divider = 1'b0; data = DW'(stp); load_step = 1'b1; cyc();
        load_step = 1'b0; data = '0; cyc();
        chk("prep_zero", int'(r2r_out), 0);
        mode = md;
    endtask

    task automatic expect_seq(input string nm, input int vals[], input int syncs[]);
        foreach (vals[i]) begin
            cyc();
            chk({nm, "_out"}, int'(r2r_out), vals[i]);
            chk({nm, "_sync"}, int'(sync), syncs[i]);
        end
    endtask

    int g, nsync, frozen;

    initial begin
        #1 n_rst = 1'b0;
        cyc(); cyc();
        chk("reset_out", int'(r2r_out), 0);
        chk("reset_sync", int'(sync), 0);
        n_rst = 1'b1; run = 1; mode = 2'd1;

        // Sawtooth, divider 0, step 1
        nsync = 0;
        for (int k = 1; k <= 256; k++) begin
            cyc();
            nsync += int'(sync);
            if (k == 255) chk("saw_at255", int'(r2r_out), 255);
            if (k == 256) begin
                chk("saw_wrap_out", int'(r2r_out), 0);
                chk("saw_wrap_sync", int'(sync), 1);
            end
        end
        chk("saw_sync_count", nsync, 1);

        // Divider 1 then 2
        data = 8'd1; load_divider = 1'b1; cyc(); load_divider = 1'b0;
        gap_to_change(g); gap_to_change(g);
        chk("div1_gap", g, 257);
        data = 8'd2; load_divider = 1'b1; cyc(); load_divider = 1'b0;
        gap_to_change(g); gap_to_change(g);
        chk("div2_gap", g, 513);

        // Triangle step 64, then step 255
        prep(64, 0, 2'd2);
        expect_seq("tri64", '{64, 128, 192, 255, 191, 127, 63, 0, 64},
                   '{0, 0, 0, 0, 0, 0, 0, 1, 0});
        prep(255, 0, 2'd2);
        expect_seq("tri255", '{255, 0, 255}, '{0, 1, 0});

        // Square from nonzero, then external
        mode = 2'd3;
        expect_seq("sqr", '{0, 255, 0, 255}, '{0, 1, 0, 1});
        mode = 2'd0; data = 8'hA5;
        expect_seq("ext", '{165}, '{0});

        // Triangle step 127 down to 128, then async reset between edges
        prep(127, 0, 2'd2);
        expect_seq("tri127", '{127, 254, 255, 128}, '{0, 0, 0, 0});
        #2 n_rst = 1'b0;
        #1;
        chk("async_rst_out", int'(r2r_out), 0);
        chk("async_rst_sync", int'(sync), 0);
        cyc(); n_rst = 1'b1;
        expect_seq("post_rst", '{1, 2, 3}, '{0, 0, 0});

        // Joint load of divider and step, then step 0 freeze
        mode = 2'd1; data = 8'd3; load_divider = 1'b1; load_step = 1'b1; cyc();
        load_divider = 1'b0; load_step = 1'b0;
        gap_to_change(g);
        frozen = int'(r2r_out);
        gap_to_change(g);
        chk("joint_div_gap", g, 769);
        chk("joint_step", (int'(r2r_out) - frozen + 256) % 256, 3);
        data = 8'd0; load_divider = 1'b1; load_step = 1'b1; cyc();
        load_divider = 1'b0; load_step = 1'b0; cyc();
        frozen = int'(r2r_out);
        nsync = 0;
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (int'(r2r_out) != frozen) nsync++;
            nsync += int'(sync);
        end
        chk("step0_frozen", nsync, 0);

        // Randomized traffic against the model
        for (int k = 0; k < 6000; k++) begin
            cyc();
            load_divider = 1'b0; load_step = 1'b0;
            if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
            data = 8'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                data = 8'($urandom_range(0, 1));
                load_divider = 1'b1;
                load_step = ($urandom_range(0, 3) == 0);
            end else if ($urandom_range(0, 30) == 0) begin
                load_step = 1'b1;
            end
            if ($urandom_range(0, 999) == 0) begin
                #3 n_rst = 1'b0;
                cyc(); n_rst = 1'b1;
            end
        end

        cyc();
        run = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
